sprite_load_scheduler: RTL

//  Time-shares one sprite bitmap ROM among NUM_SPRITES sprite renderers during horizontal blank.

---
 rtl/sprite_load_scheduler_pkg.sv | 24 ++
 rtl/sprite_load_scheduler_rr_pick.sv | 28 ++
 rtl/sprite_load_scheduler.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sprite_load_scheduler_pkg.sv
// Shared definitions for the sprite load scheduler: FSM encodings, default blank timing
// matching hvsync_generator, and a small popcount helper for the miss statistics.
package sprite_load_scheduler_pkg;

    localparam logic [1:0] SCHED_IDLE = 2'd0;
    localparam logic [1:0] SCHED_ARB  = 2'd1;
    localparam logic [1:0] SCHED_LOAD = 2'd2;

    localparam int DEFAULT_HBLANK_START = 256;
    localparam int DEFAULT_HBLANK_END   = 308;

    localparam int MAX_SPRITES = 8;

    // Number of set bits in a request vector, zero-extended to MAX_SPRITES bits by the caller.
    function automatic logic [3:0] count_ones(input logic [MAX_SPRITES-1:0] vec);
        logic [3:0] total;
        total = 4'd0;
        for (int i = 0; i < MAX_SPRITES; i++) begin
            total = total + {3'd0, vec[i]};
        end
        return total;
    endfunction

endpackage

// File: rtl/sprite_load_scheduler_rr_pick.sv
// rr_pick: combinational rotating-priority encoder. Returns the first set bit of vec
// found scanning start, start+1, ... with wrap at N; shared by the ROM arbiters.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int i = 0; i < N; i++) begin
            pos = IDX_W'((int'(start) + i) % N);
            if (!found && vec[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/sprite_load_scheduler.sv
// Time-shares one sprite ROM among the renderers during horizontal blank with a compacting,
// fairly rotating slot schedule. Define SPRITE_SCHED_STATS_EN to add missed_cnt/frame_clr.
module sprite_load_scheduler
    import sprite_load_scheduler_pkg::*;
#(
    parameter int NUM_SPRITES  = 4,
    parameter int ADDR_W       = 4,
    parameter int SLOT_CYCLES  = 4,
    parameter int HBLANK_START = DEFAULT_HBLANK_START,
    parameter int HBLANK_END   = DEFAULT_HBLANK_END
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [8:0]                    hpos,
    input  logic [NUM_SPRITES-1:0]        req,
    input  logic [NUM_SPRITES*ADDR_W-1:0] addr_in,
`ifdef SPRITE_SCHED_STATS_EN
    input  logic                          frame_clr,
    output logic [7:0]                    missed_cnt,
`endif
    output logic [NUM_SPRITES-1:0]        load,
    output logic [ADDR_W-1:0]             rom_addr,
    output logic                          busy,
    output logic                          overrun
);

    localparam int IDX_W = $clog2(NUM_SPRITES);
    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    localparam logic [8:0]       HB_START = 9'(HBLANK_START);
    localparam logic [8:0]       HB_END   = 9'(HBLANK_END);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

    logic [1:0]             state;
    logic [NUM_SPRITES-1:0] pending;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       line_ptr;
    logic [IDX_W-1:0]       sel;
    logic [CNT_W-1:0]       cnt;
    logic [ADDR_W-1:0]      addr_hold;

    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;
    logic                   line_start;
    logic                   abort;

    logic [ADDR_W-1:0]      addr_arr [NUM_SPRITES];

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_addr_split
        assign addr_arr[g] = addr_in[g*ADDR_W +: ADDR_W];
    end

    assign line_start = (hpos == HB_START);
    assign abort      = (hpos == HB_END) && (state != SCHED_IDLE);
    assign busy       = (state != SCHED_IDLE);

    // The scan origin is frozen per line (line_ptr) so rr_ptr's advance only affects the next line.
    rr_pick #(
        .N     (NUM_SPRITES),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .vec   (pending),
        .start (line_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Window sequencer: line start (also on an hpos jump mid-window), abort at the end of the
    // line, otherwise ARB picks the next pending sprite and LOAD holds its strobe for a slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= SCHED_IDLE;
            pending  <= '0;
            rr_ptr   <= '0;
            line_ptr <= '0;
            sel      <= '0;
            cnt      <= '0;
            load     <= '0;
            overrun  <= 1'b0;
        end else if (line_start) begin
            pending  <= req;
            line_ptr <= rr_ptr;
            rr_ptr   <= (rr_ptr == LAST_IDX) ? '0 : rr_ptr + 1'b1;
            overrun  <= (state != SCHED_IDLE);
            load     <= '0;
            state    <= SCHED_ARB;
        end else if (abort) begin
            load    <= '0;
            overrun <= overrun | (|pending);
            state   <= SCHED_IDLE;
        end else begin
            case (state)
                SCHED_ARB: begin
                    if (pick_found) begin
                        sel   <= pick_idx;
                        cnt   <= CNT_W'(SLOT_CYCLES - 1);
                        load  <= NUM_SPRITES'(1) << pick_idx;
                        state <= SCHED_LOAD;
                    end else begin
                        state <= SCHED_IDLE;
                    end
                end
                SCHED_LOAD: begin
                    if (cnt == '0) begin
                        pending[sel] <= 1'b0;
                        load         <= '0;
                        state        <= SCHED_ARB;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= SCHED_IDLE;
            endcase
        end
    end

    // Remembers the address driven during the most recent load cycle so rom_addr holds it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_hold <= '0;
        end else if (state == SCHED_LOAD) begin
            addr_hold <= addr_arr[sel];
        end
    end

    assign rom_addr = (state == SCHED_LOAD) ? addr_arr[sel] : addr_hold;

`ifdef SPRITE_SCHED_STATS_EN
    logic [8:0] missed_sum;

    assign missed_sum = {1'b0, missed_cnt} + {5'd0, count_ones(MAX_SPRITES'(pending))};

    // Saturating count of sprites left unserved by aborts; a frame clear beats an increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            missed_cnt <= 8'd0;
        end else if (frame_clr) begin
            missed_cnt <= 8'd0;
        end else if (abort) begin
            missed_cnt <= missed_sum[8] ? 8'hFF : missed_sum[7:0];
        end
    end
`endif

endmodule
